// File: rtl/des_key_schedule_rev.sv
// DES key schedule that emits the 16 round subkeys in decryption order (K16 first, K1 last)
// using a valid/ready handshake. It takes the C0/D0 halves that come out of PC-1.
module des_key_schedule_rev (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [27:0] C0,
    input  logic [27:0] D0,
    input  logic        Ready,
    output logic        Key_valid,
    output logic [47:0] Subkey,
    output logic [3:0]  Round,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // FIPS 46-3 PC-2, 1-based positions into the 56-bit CD word; CD bit 1 is the MSB
    localparam logic [5:0] PC2_TAB [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        logic [5:0]  pos;
        k = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            pos = 6'd56 - PC2_TAB[6'(i)];
            k[6'(47 - i)] = cd[pos];
        end
        return k;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic one);
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        done_q, done_d;
    logic        shift_one;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    // Undoing the encryption left shifts: the step leaving round index r reverses the shift of DES round r+1
    assign shift_one = (round_q == 4'd15) || (round_q == 4'd8) || (round_q == 4'd1);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    c_d     = C0;
                    d_d     = D0;
                    round_d = 4'd15;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (Ready) begin
                    if (round_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        c_d     = rotr(c_q, shift_one);
                        d_d     = rotr(d_q, shift_one);
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Key_valid = (state_q == EMIT);
    assign Busy      = (state_q == EMIT);
    assign Done      = done_q;
    assign Round     = round_q;
    assign Subkey    = pc2({c_q, d_q});

endmodule

// File: tb/tb_des_key_schedule_rev.sv
// Directed bench for des_key_schedule_rev: expected subkeys come from a forward DES key schedule
// (left rotations, K1..K16), with the published K16/K15/K1 values checked as literals.
module tb_des_key_schedule_rev;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [27:0] C0;
    logic [27:0] D0;
    logic        Ready;
    logic        Key_valid;
    logic [47:0] Subkey;
    logic [3:0]  Round;
    logic        Busy;
    logic        Done;

    localparam logic [27:0] KC = 28'hF0CCAAF;
    localparam logic [27:0] KD = 28'h556678F;

    int n_checks = 0;
    int n_pass   = 0;
    int nvalid;
    logic [47:0] expk [16];

    des_key_schedule_rev dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .C0        (C0),
        .D0        (D0),
        .Ready     (Ready),
        .Key_valid (Key_valid),
        .Subkey    (Subkey),
        .Round     (Round),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [47:0] pc2_model(input logic [55:0] cd);
        int tab [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                         23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                         41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                         44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
        logic [47:0] k;
        for (int j = 1; j <= 48; j++)
            k[48 - j] = cd[56 - tab[j - 1]];
        return k;
    endfunction

    task automatic build_model(input logic [27:0] c_in, input logic [27:0] d_in);
        int sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        logic [27:0] c;
        logic [27:0] d;
        c = c_in;
        d = d_in;
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < sh[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            expk[i] = pc2_model({c, d});
        end
    endtask

    task automatic expect_key(input int r, input logic [47:0] k);
        check($sformatf("key_valid r%0d", r), 64'(Key_valid), 64'd1);
        check($sformatf("busy r%0d", r), 64'(Busy), 64'd1);
        check($sformatf("round r%0d", r), 64'(Round), 64'(r));
        check($sformatf("subkey r%0d", r), 64'(Subkey), 64'(k));
    endtask

    task automatic expect_idle_zero(input string tag);
        check({tag, " key_valid"}, 64'(Key_valid), 64'd0);
        check({tag, " busy"}, 64'(Busy), 64'd0);
        check({tag, " done"}, 64'(Done), 64'd0);
        check({tag, " subkey"}, 64'(Subkey), 64'd0);
        check({tag, " round"}, 64'(Round), 64'd0);
    endtask

    task automatic start_seq(input logic [27:0] c, input logic [27:0] d);
        @(negedge Clk);
        C0    = c;
        D0    = d;
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        Ready = 1'b0;
        C0    = '0;
        D0    = '0;
        build_model(KC, KD);

        #3 expect_idle_zero("reset");
        Start = 1'b1;
        C0    = KC;
        D0    = KD;
        #10 expect_idle_zero("reset_start");
        Start = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("idle key_valid", 64'(Key_valid), 64'd0);
        check("idle busy", 64'(Busy), 64'd0);

        // Full sequence with Ready held high
        Ready = 1'b1;
        start_seq(KC, KD);
        nvalid = 0;
        for (int r = 15; r >= 0; r--) begin
            @(negedge Clk);
            expect_key(r, expk[r]);
            if (Key_valid) nvalid++;
            if (r == 15) check("k16 literal", 64'(Subkey), 64'h0000_CB3D8B0E17F5);
            if (r == 14) check("k15 literal", 64'(Subkey), 64'h0000_BF918D3D3F0A);
            if (r == 0)  check("k1 literal", 64'(Subkey), 64'h0000_1B02EFFC7072);
        end
        @(negedge Clk);
        check("a done", 64'(Done), 64'd1);
        check("a done busy", 64'(Busy), 64'd0);
        check("a done key_valid", 64'(Key_valid), 64'd0);
        check("a valid_count", 64'(nvalid), 64'd16);
        @(negedge Clk);
        check("a done pulse width", 64'(Done), 64'd0);

        // Back-pressure at round 10, ignored Start at round 7
        start_seq(KC, KD);
        for (int r = 15; r >= 0; r--) begin
            @(negedge Clk);
            Start = 1'b0;
            expect_key(r, expk[r]);
            if (r == 10) begin
                Ready = 1'b0;
                repeat (3) begin
                    @(negedge Clk);
                    expect_key(10, expk[10]);
                end
                Ready = 1'b1;
            end
            if (r == 7) begin
                Start = 1'b1;
                C0    = 28'h1234567;
                D0    = 28'hABCDEF0;
            end
        end
        @(negedge Clk);
        check("b done", 64'(Done), 64'd1);
        check("b done busy", 64'(Busy), 64'd0);

        // Start in the Done cycle with an all-zero key
        Start = 1'b1;
        C0    = '0;
        D0    = '0;
        @(negedge Clk);
        Start = 1'b0;
        expect_key(15, 48'h0);
        for (int r = 14; r >= 0; r--) begin
            @(negedge Clk);
            check($sformatf("zero round r%0d", r), 64'(Round), 64'(r));
            check($sformatf("zero subkey r%0d", r), 64'(Subkey), 64'd0);
        end
        @(negedge Clk);
        check("z done", 64'(Done), 64'd1);

        // Asynchronous reset at round 5
        start_seq(KC, KD);
        for (int r = 15; r >= 5; r--) begin
            @(negedge Clk);
            expect_key(r, expk[r]);
        end
        #2 Reset = 1'b0;
        #1 expect_idle_zero("async reset");
        repeat (2) begin
            @(negedge Clk);
            expect_idle_zero("held reset");
        end
        Reset = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("post reset key_valid", 64'(Key_valid), 64'd0);
            check("post reset done", 64'(Done), 64'd0);
            check("post reset busy", 64'(Busy), 64'd0);
        end
        start_seq(KC, KD);
        for (int r = 15; r >= 0; r--) begin
            @(negedge Clk);
            expect_key(r, expk[r]);
        end
        @(negedge Clk);
        check("c done", 64'(Done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/des_key_schedule_rev.md
DES_KEY_SCHEDULE_REV -- requirements
Module: des_key_schedule_rev

Interface
REQ-001 The block SHALL have no parameters; the round count (16) and shift schedule are fixed by DES.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 Start  input  1  one-cycle request to begin a decryption key sequence.
REQ-005 C0  input  28  left key half after PC-1; C0[27] = DES CD bit 1.
REQ-006 D0  input  28  right key half after PC-1; D0[27] = DES CD bit 29.
REQ-007 Ready  input  1  consumer accepts the current Subkey this cycle.
REQ-008 Key_valid  output  1  Subkey and Round are valid.
REQ-009 Subkey  output  48  PC-2 of the current C/D; Subkey[47] = PC-2 output bit 1.
REQ-010 Round  output  4  DES round index minus 1 of the current Subkey (15 = K16 ... 0 = K1).
REQ-011 Busy  output  1  a sequence is in progress.
REQ-012 Done  output  1  one-cycle pulse after K1 is accepted.

Function
REQ-013 The block SHALL emit the 16 DES subkeys in decryption order K16, K15, ..., K1.
REQ-014 FSM states SHALL be IDLE and EMIT only.
REQ-015 IDLE: Key_valid=0, Busy=0; on Start=1, latch C0/D0 into C_reg/D_reg, load Round=15, and go to EMIT.
REQ-016 Latency: Start sampled at edge N SHALL give Key_valid=1 with Subkey=K16 in the cycle after edge N.
REQ-017 EMIT: Key_valid=1, Busy=1; Subkey SHALL be combinational PC-2(C_reg,D_reg) and SHALL stay stable while Ready=0.
REQ-018 Acceptance SHALL occur only on an edge with Key_valid=1 and Ready=1.
REQ-019 On acceptance with Round>0, C_reg and D_reg SHALL each rotate right by s(Round) and Round SHALL decrement by 1.
REQ-020 s(Round) SHALL be 1 for Round in {15, 8, 1} and 2 otherwise; K16 uses no shift, and total shifts through K1 = 27.
REQ-021 On acceptance with Round=0, go to IDLE and pulse Done=1 for exactly one cycle.
REQ-022 Start in EMIT SHALL be ignored; C0/D0 changes in EMIT SHALL have no effect.
REQ-023 Start in the same cycle that Done pulses SHALL be accepted, giving the next K16 one cycle after that edge.
REQ-024 With Ready held high, 16 subkeys SHALL appear on 16 consecutive cycles.
REQ-025 The PC-2 table SHALL be FIPS 46-3 PC-2 with MSB-first bit numbering.

Reset
REQ-026 While Reset=0, Key_valid, Busy and Done SHALL be 0, Subkey SHALL read 0, and C_reg, D_reg and Round SHALL be 0; the FSM SHALL be held in IDLE.
REQ-027 Reset asserted mid-sequence SHALL abort at once, with no Done pulse.
REQ-028 After Reset deasserts, the block SHALL wait in IDLE for a new Start.

Verification
REQ-029 Reset=0 at time 0, then release; pulse Start with C0=28'hF0CCAAF, D0=28'h556678F, Ready=1 -> next cycle Subkey=48'hCB3D8B0E17F5 and Round=15, next Subkey=48'hBF918D3D3F0A and Round=14, and the 16th Subkey=48'h1B02EFFC7072 with Round=0.
REQ-030 Same stimulus, with Done checked -> Done=1 on the cycle after K1 is accepted, Busy=0 on that same cycle, and exactly 16 Key_valid cycles.
REQ-031 Ready=0 for 3 cycles while Round=10, then 1 -> Subkey and Round held constant for those 3 cycles, then the sequence continues with no skipped or repeated key.
REQ-032 Start pulsed again while Round=7, with different C0/D0 -> ignored, and the remaining keys match the first key.
REQ-033 Reset=0 asserted while Round=5 -> all outputs 0 asynchronously and no Done pulse; a new Start then restarts at K16.
REQ-034 Start asserted in the Done cycle with C0=28'h0000000, D0=28'h0000000 -> next cycle Key_valid=1, Round=15, Subkey=48'h000000000000.
